alu_mdu: RTL

- Parametrised successor to the single-cycle datapath ALU.
- Keeps a combinational arithmetic/logic path for the execute stage.
- Adds an iterative multiply/divide unit with HI/LO registers and a start/busy handshake, which the controller uses to stall the pipeline.
- Sits in the execute stage; HI/LO are readable by the mfhi/mflo datapath mux.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/mdu_iter.sv | 111 +++++++++++
 rtl/alu_mdu.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and its multiply/divide unit:
// operation encoding, FSM state encoding and a small op-class helper.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_OR    = 4'd2;
    localparam logic [3:0] ALU_LUI   = 4'd3;
    localparam logic [3:0] ALU_AND   = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_NOR   = 4'd8;
    localparam logic [3:0] ALU_MULT  = 4'd9;
    localparam logic [3:0] ALU_MULTU = 4'd10;
    localparam logic [3:0] ALU_DIV   = 4'd11;
    localparam logic [3:0] ALU_DIVU  = 4'd12;
    localparam logic [3:0] ALU_MTHI  = 4'd13;
    localparam logic [3:0] ALU_MTLO  = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_t;

    // True for the ops that occupy the iterative unit for WIDTH+1 cycles.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) ||
               (op == ALU_DIV)  || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: operand magnitudes are latched on load,
// one shift-add or restoring-subtract step runs per i_step cycle, and the
// sign-corrected HI/LO result is presented combinationally for the FIX cycle.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    // r_acc: upper product half / partial remainder
    // r_mq : multiplier shifting out / dividend shifting out, quotient in
    // r_md : multiplicand / divisor magnitude
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_md;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_neg_p;   // product / quotient negative
    logic             r_neg_r;   // remainder negative (dividend sign)
    logic             r_dz;      // divisor was zero

    logic             w_signed;
    logic             w_div_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_rsh;
    logic [WIDTH:0]   w_dsub;
    logic             w_qbit;
    logic [2*WIDTH-1:0] w_prod;

    // Operand decode for the load cycle and per-step arithmetic.
    always_comb begin
        w_signed = (i_op == ALU_MULT) || (i_op == ALU_DIV);
        w_div_op = (i_op == ALU_DIV)  || (i_op == ALU_DIVU);
        w_a_neg  = w_signed & i_a[WIDTH-1];
        w_b_neg  = w_signed & i_b[WIDTH-1];
        w_a_mag  = w_a_neg ? (~i_a + 1'b1) : i_a;
        w_b_mag  = w_b_neg ? (~i_b + 1'b1) : i_b;

        w_madd   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_md} : '0);
        w_rsh    = {r_acc, r_mq[WIDTH-1]};
        // Partial remainder stays below the divisor, so bit WIDTH of the
        // difference is a clean borrow flag (and with a zero divisor every
        // step "succeeds", leaving quotient all ones and remainder = dividend).
        w_dsub   = w_rsh - {1'b0, r_md};
        w_qbit   = ~w_dsub[WIDTH];
    end

    // Load magnitudes/signs, then advance one iteration per step cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mq     <= '0;
            r_md     <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_p  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mq     <= w_a_mag;
            r_md     <= w_b_mag;
            r_cnt    <= '0;
            r_is_div <= w_div_op;
            r_neg_p  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= (i_b == '0);
        end else if (i_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) begin
                r_acc <= w_qbit ? w_dsub[WIDTH-1:0] : w_rsh[WIDTH-1:0];
                r_mq  <= {r_mq[WIDTH-2:0], w_qbit};
            end else begin
                {r_acc, r_mq} <= {w_madd, r_mq[WIDTH-1:1]};
            end
        end
    end

    // Sign fix-up of the finished magnitudes into HI/LO form.
    always_comb begin
        o_last = (r_cnt == CNT_W'(WIDTH - 1));
        w_prod = {r_acc, r_mq};
        if (r_neg_p) begin
            w_prod = ~w_prod + 1'b1;
        end
        if (r_is_div) begin
            o_lo = r_dz ? '1 : (r_neg_p ? (~r_mq + 1'b1) : r_mq);
            o_hi = r_neg_r ? (~r_acc + 1'b1) : r_acc;
        end else begin
            o_hi = w_prod[2*WIDTH-1:WIDTH];
            o_lo = w_prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: combinational arithmetic/logic result plus an iterative
// multiply/divide unit writing HI/LO, with a start/busy/done handshake used
// by the controller to stall the pipeline.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             start,
    output logic [WIDTH-1:0] aluout,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t       r_state;
    mdu_state_t       w_next;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic             w_fix;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_last;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_aluout;
    logic             w_ovf;

    // Combinational ALU result, independent of the multiply/divide unit.
    always_comb begin
        w_sum    = a + b;
        w_diff   = a - b;
        w_aluout = '0;
        w_ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                w_aluout = w_sum;
                w_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_aluout = w_diff;
                w_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_OR:   w_aluout = a | b;
            ALU_LUI:  w_aluout = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_AND:  w_aluout = a & b;
            ALU_XOR:  w_aluout = a ^ b;
            ALU_SLT:  w_aluout = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: w_aluout = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_NOR:  w_aluout = ~(a | b);
            default:  w_aluout = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control strobes; start is only honoured in IDLE.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        w_mthi = 1'b0;
        w_mtlo = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (is_muldiv(op)) begin
                        w_load = 1'b1;
                        w_next = S_RUN;
                    end
                    w_mthi = (op == ALU_MTHI);
                    w_mtlo = (op == ALU_MTLO);
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_fix  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // HI/LO registers and the done pulse that accompanies a new result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_fix) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else begin
                if (w_mthi) r_hi <= a;
                if (w_mtlo) r_lo <= a;
            end
        end
    end

    mdu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mdu_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_step (w_step),
        .i_a    (a),
        .i_b    (b),
        .i_op   (op),
        .o_last (w_last),
        .o_hi   (w_res_hi),
        .o_lo   (w_res_lo)
    );

    assign aluout   = w_aluout;
    assign zero     = (w_aluout == '0);
    assign overflow = w_ovf;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
